// File: rtl/hash_msg_feeder.sv
// Buffers message bytes and replays them to the DES hash core at one byte per two cycles.
// Captures the digest on the hash_ready rising edge and offers it downstream until accepted.
module hash_msg_feeder #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_valid,
  output logic        start_ready,
  input  logic [63:0] msg_len,
  input  logic        byte_valid,
  output logic        byte_ready,
  input  logic [7:0]  byte_data,
  output logic        M_valid,
  output logic [7:0]  message,
  output logic [63:0] counter,
  input  logic        hash_ready,
  input  logic [31:0] digest_in,
  output logic        dig_valid,
  input  logic        dig_ready,
  output logic [31:0] dig_data,
  output logic        err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_GAP, S_WAIT, S_HOLD} state_t;

  state_t         state_q, state_d;
  logic           init_q;
  logic [7:0]     mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q;
  logic [63:0]    rem_q, rem_d;
  logic [63:0]    counter_q, counter_d;
  logic [TW-1:0]  tmr_q, tmr_d;
  logic           hr_q;
  logic [31:0]    dig_data_q, dig_data_d;
  logic           err_q, err_d;

  logic fifo_empty, push, pop;

  assign fifo_empty = (count_q == '0);
  assign byte_ready = (count_q != CW'(DEPTH));
  assign push       = byte_valid & byte_ready;
  assign pop        = (state_q == S_ISSUE) & ~fifo_empty;

  assign M_valid     = pop;
  assign message     = pop ? mem_q[rd_ptr_q] : 8'h00;
  // init_q keeps start_ready low while reset is held, even though the state is IDLE.
  assign start_ready = (state_q == S_IDLE) & init_q;
  assign busy        = (state_q != S_IDLE);
  assign dig_valid   = (state_q == S_HOLD);
  assign counter     = counter_q;
  assign dig_data    = dig_data_q;
  assign err         = err_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= byte_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      init_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rem_q      <= '0;
      counter_q  <= '0;
      tmr_q      <= '0;
      hr_q       <= 1'b0;
      dig_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_q     <= 1'b1;
      rem_q      <= rem_d;
      counter_q  <= counter_d;
      tmr_q      <= tmr_d;
      hr_q       <= hash_ready;
      dig_data_q <= dig_data_d;
      err_q      <= err_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    counter_d  = counter_q;
    tmr_d      = tmr_q;
    dig_data_d = dig_data_q;
    err_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_valid && init_q) begin
          if (msg_len == 64'd0) begin
            err_d = 1'b1;
          end else begin
            counter_d = msg_len;
            rem_d     = msg_len;
            state_d   = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (!fifo_empty) begin
          rem_d   = rem_q - 64'd1;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        // One idle strobe cycle per byte so the core can process it.
        if (rem_q == 64'd0) begin
          tmr_d   = '0;
          state_d = S_WAIT;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_WAIT: begin
        tmr_d = tmr_q + TW'(1);
        if (hash_ready && !hr_q) begin
          dig_data_d = digest_in;
          state_d    = S_HOLD;
        end else if (tmr_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_HOLD: begin
        if (dig_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_hash_msg_feeder.sv
// Bench for hash_msg_feeder: byte feeder, behavioural hash core and a byte-stream reference model.
module tb_hash_msg_feeder;

  logic        clk, rst_n;
  logic        start_valid, start_ready;
  logic [63:0] msg_len;
  logic        byte_valid, byte_ready;
  logic [7:0]  byte_data;
  logic        M_valid;
  logic [7:0]  message;
  logic [63:0] counter;
  logic        hash_ready;
  logic [31:0] digest_in;
  logic        dig_valid, dig_ready;
  logic [31:0] dig_data;
  logic        err, busy;

  hash_msg_feeder #(.DEPTH(16), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(start_ready), .msg_len(msg_len),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_data(byte_data),
    .M_valid(M_valid), .message(message), .counter(counter),
    .hash_ready(hash_ready), .digest_in(digest_in),
    .dig_valid(dig_valid), .dig_ready(dig_ready), .dig_data(dig_data),
    .err(err), .busy(busy)
  );

  typedef struct {
    int         len;
    logic [7:0] b0;
    int         nb;
    int         gap;
    bit         pre;
    bit         cen;
    int         rdy;
    bit         exp_err;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [7:0] tx_q[$];
  logic [7:0] ref_q[$];
  logic [7:0] iss_q[$];
  logic [7:0] core_q[$];
  int         mv_cyc[$];
  int         feed_gap = 0;
  int         gap_cnt = 0;
  bit         feed_en = 1;
  bit         core_en = 1;
  logic [63:0] len_cur = 0;
  int         last_mv = 0;
  bit         prev_mv = 0;
  bit         prev_err = 0;
  int         pend = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] hashfn(input logic [7:0] q[$]);
    logic [31:0] h;
    h = 32'h811C9DC5;
    foreach (q[i]) h = (h ^ {24'h0, q[i]}) * 32'h01000193;
    return h;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Upstream byte producer: one byte per feed_gap cycles from tx_q.
  initial forever @(negedge clk) begin
    if (feed_en) begin
      if (gap_cnt > 0) begin
        gap_cnt--;
        byte_valid = 0;
      end else if (tx_q.size() > 0) begin
        byte_valid = 1;
        byte_data  = tx_q[0];
        if (byte_ready) begin
          void'(tx_q.pop_front());
          gap_cnt = (feed_gap > 0) ? feed_gap - 1 : 0;
        end
      end else begin
        byte_valid = 0;
      end
    end
  end

  // Behavioural core: drops hash_ready on each byte, raises it 3 cycles after the last one.
  initial forever @(negedge clk) begin
    if (!rst_n) begin
      hash_ready = 0;
      pend = 0;
    end else if (M_valid) begin
      core_q.push_back(message);
      hash_ready = 0;
      pend = 3;
    end else if (pend > 0) begin
      pend--;
      if (pend == 0 && core_en) begin
        hash_ready = 1;
        digest_in  = hashfn(core_q);
      end
    end
  end

  initial forever @(negedge clk) begin
    if (!rst_n) begin
      prev_mv = 0;
      prev_err = 0;
    end else begin
      if (M_valid) begin
        chk("mv_back_to_back", prev_mv, 0);
        chk("counter_at_strobe", counter, len_cur);
        iss_q.push_back(message);
        mv_cyc.push_back(cyc);
        last_mv = cyc;
      end
      if (err) chk("err_width", prev_err, 0);
      prev_mv = M_valid;
      prev_err = err;
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_start_ready"}, start_ready, 0);
    chk({tag, "_M_valid"}, M_valid, 0);
    chk({tag, "_message"}, message, 0);
    chk({tag, "_counter"}, counter, 0);
    chk({tag, "_dig_valid"}, dig_valid, 0);
    chk({tag, "_dig_data"}, dig_data, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_byte_ready"}, byte_ready, 1);
  endtask

  task automatic finish_msg(input logic [7:0] exp[$], input bit exp_err, input bit pre,
                            input int acc, input int rdy);
    int n;
    logic [31:0] d;
    n = 0;
    while (!dig_valid && !err && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("byte_count", iss_q.size(), exp.size());
    for (int i = 0; i < iss_q.size() && i < exp.size(); i++) chk("byte_order", iss_q[i], exp[i]);
    if (!exp_err) begin
      chk("dig_valid_seen", dig_valid, 1);
      chk("dig_latency", cyc, last_mv + 4);
      chk("dig_data", dig_data, hashfn(exp));
      if (pre)
        for (int i = 0; i < mv_cyc.size(); i++) chk("mv_cadence", mv_cyc[i], acc + 1 + 2 * i);
      d = dig_data;
      for (int k = 0; k < rdy; k++) begin
        @(negedge clk);
        chk("hold_valid", dig_valid, 1);
        chk("hold_data", dig_data, d);
      end
      dig_ready = 1;
      @(negedge clk);
      dig_ready = 0;
      chk("dig_valid_cleared", dig_valid, 0);
      chk("idle_after_dig", busy, 0);
      chk("start_ready_after_dig", start_ready, 1);
    end else begin
      chk("timeout_err", err, 1);
      chk("timeout_cycle", cyc, last_mv + 17);
      chk("timeout_no_dig", dig_valid, 0);
      @(negedge clk);
      chk("timeout_err_one_cycle", err, 0);
      chk("timeout_idle", busy, 0);
    end
  endtask

  task automatic run_msg(input vec_t v);
    logic [7:0] exp[$];
    int acc, n;
    feed_gap = v.gap;
    core_en = v.cen;
    for (int i = 0; i < v.nb; i++) begin
      tx_q.push_back(v.b0 + 8'(i));
      ref_q.push_back(v.b0 + 8'(i));
    end
    if (v.pre) begin
      n = 0;
      while (tx_q.size() > 0 && n < 300) begin
        @(negedge clk);
        n++;
      end
      @(negedge clk);
    end
    for (int i = 0; i < v.len; i++) exp.push_back(ref_q.pop_front());
    iss_q.delete();
    mv_cyc.delete();
    core_q.delete();
    len_cur = 64'(v.len);
    n = 0;
    while (!start_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    start_valid = 1;
    msg_len = 64'(v.len);
    acc = cyc;
    @(negedge clk);
    start_valid = 0;
    if (v.len == 0) begin
      chk("zero_len_err", err, v.exp_err);
      chk("zero_len_start_ready", start_ready, 1);
      chk("zero_len_busy", busy, 0);
      @(negedge clk);
      chk("zero_len_err_one_cycle", err, 0);
      chk("zero_len_no_strobe", iss_q.size(), 0);
    end else begin
      chk("busy_after_start", busy, 1);
      chk("counter_latched", counter, 64'(v.len));
      finish_msg(exp, v.exp_err, v.pre, acc, v.rdy);
    end
  endtask

  vec_t tbl[8];

  initial begin
    logic [7:0] e1[$];
    int n;
    vec_t rv;
    tbl[0] = '{len: 1,  b0: 8'h41, nb: 1,  gap: 0, pre: 1, cen: 1, rdy: 0,  exp_err: 0};
    tbl[1] = '{len: 5,  b0: 8'h10, nb: 5,  gap: 0, pre: 1, cen: 1, rdy: 0,  exp_err: 0};
    tbl[2] = '{len: 5,  b0: 8'h10, nb: 5,  gap: 7, pre: 0, cen: 1, rdy: 1,  exp_err: 0};
    tbl[3] = '{len: 0,  b0: 8'hA0, nb: 3,  gap: 0, pre: 1, cen: 1, rdy: 0,  exp_err: 1};
    tbl[4] = '{len: 3,  b0: 8'h00, nb: 0,  gap: 0, pre: 1, cen: 1, rdy: 0,  exp_err: 0};
    tbl[5] = '{len: 3,  b0: 8'h5C, nb: 3,  gap: 0, pre: 1, cen: 0, rdy: 0,  exp_err: 1};
    tbl[6] = '{len: 16, b0: 8'hE8, nb: 16, gap: 0, pre: 1, cen: 1, rdy: 10, exp_err: 0};
    tbl[7] = '{len: 20, b0: 8'h33, nb: 20, gap: 0, pre: 0, cen: 1, rdy: 2,  exp_err: 0};

    rst_n = 0;
    start_valid = 0;
    msg_len = 0;
    byte_valid = 0;
    byte_data = 0;
    dig_ready = 0;
    hash_ready = 0;
    digest_in = 0;
    @(negedge clk);
    chk_reset("reset");
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("start_ready_after_reset", start_ready, 1);

    foreach (tbl[i]) run_msg(tbl[i]);

    // Simultaneous push and pop at 15 entries, then fill to full.
    core_en = 1;
    feed_gap = 0;
    for (int i = 0; i < 15; i++) begin
      tx_q.push_back(8'h80 + 8'(i));
      ref_q.push_back(8'h80 + 8'(i));
    end
    n = 0;
    while (tx_q.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    feed_en = 0;
    byte_valid = 0;
    chk("ready_at_15", byte_ready, 1);
    e1.delete();
    e1.push_back(ref_q.pop_front());
    iss_q.delete();
    mv_cyc.delete();
    core_q.delete();
    len_cur = 1;
    start_valid = 1;
    msg_len = 1;
    @(negedge clk);
    start_valid = 0;
    chk("pp_strobe", M_valid, 1);
    chk("pp_ready_in_issue", byte_ready, 1);
    byte_valid = 1;
    byte_data = 8'hC3;
    ref_q.push_back(8'hC3);
    @(negedge clk);
    chk("pp_count_kept", byte_ready, 1);
    byte_data = 8'hC4;
    ref_q.push_back(8'hC4);
    @(negedge clk);
    byte_valid = 0;
    chk("full_ready_low", byte_ready, 0);
    finish_msg(e1, 0, 0, 0, 0);
    feed_en = 1;
    run_msg('{len: 16, b0: 8'h00, nb: 0, gap: 0, pre: 1, cen: 1, rdy: 0, exp_err: 0});

    // Reset in the middle of a stalled message.
    feed_gap = 0;
    for (int i = 0; i < 4; i++) tx_q.push_back(8'h70 + 8'(i));
    len_cur = 8;
    iss_q.delete();
    core_q.delete();
    start_valid = 1;
    msg_len = 8;
    @(negedge clk);
    start_valid = 0;
    repeat (5) @(negedge clk);
    rst_n = 0;
    tx_q.delete();
    ref_q.delete();
    #1;
    chk_reset("mid_reset");
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("start_ready_after_mid_reset", start_ready, 1);
    run_msg('{len: 2, b0: 8'h11, nb: 2, gap: 0, pre: 1, cen: 1, rdy: 0, exp_err: 0});

    for (int r = 0; r < 10; r++) begin
      rv.len = $urandom_range(1, 12);
      rv.b0 = 8'($urandom);
      rv.nb = rv.len;
      rv.gap = $urandom_range(0, 3);
      rv.pre = 0;
      rv.cen = 1;
      rv.rdy = $urandom_range(0, 3);
      rv.exp_err = 0;
      run_msg(rv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
